// File: rtl/sample_decimator_pkg.sv
// Shared widths and helpers for the sample decimator.
// The byte-lane mask helper is used only when SAMPLE_DECIMATOR_GROUP_MASK_EN is defined.
package sample_decimator_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_DIV_WIDTH  = 24;
    localparam int unsigned GROUP_COUNT    = DEF_DATA_WIDTH / 8;

    // Expands one bit per channel group into a full-width mask of the disabled byte lanes.
    function automatic logic [DEF_DATA_WIDTH-1:0] group_mask(input logic [GROUP_COUNT-1:0] groups);
        logic [DEF_DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int g = 0; g < int'(GROUP_COUNT); g++) begin
            mask[g*8 +: 8] = {8{groups[g]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/sample_decimator_decim_counter.sv
// Divider register and decimation down-counter; raises capture for each word to forward.
// Priority: divider write, then enable low, then valid-word counting.
module decim_counter
    import sample_decimator_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = DEF_DIV_WIDTH
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 enable,
    input  logic                 validIn,
    input  logic                 wrDivider,
    input  logic [DIV_WIDTH-1:0] divider,
    output logic                 capture
);

    localparam logic [DIV_WIDTH-1:0] ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [DIV_WIDTH-1:0] div_reg_q, div_reg_d;
    logic [DIV_WIDTH-1:0] counter_q, counter_d;

    always_comb begin
        div_reg_d = div_reg_q;
        counter_d = counter_q;
        capture   = 1'b0;
        if (wrDivider) begin
            div_reg_d = divider;
            counter_d = '0;
        end else if (!enable) begin
            counter_d = '0;
        end else if (validIn) begin
            if (counter_q == '0) begin
                capture   = 1'b1;
                counter_d = div_reg_q;
            end else begin
                counter_d = counter_q - ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            div_reg_q <= '0;
            counter_q <= '0;
        end else begin
            div_reg_q <= div_reg_d;
            counter_q <= counter_d;
        end
    end

endmodule

// File: rtl/sample_decimator.sv
// Forwards one of every (divider+1) valid filtered words with a registered one-cycle strobe.
// Optional per-byte group masking of the captured word: SAMPLE_DECIMATOR_GROUP_MASK_EN.
module sample_decimator
    import sample_decimator_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DIV_WIDTH  = DEF_DIV_WIDTH
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic [DATA_WIDTH-1:0]   dataInput,
    input  logic                    validIn,
    input  logic                    enable,
    input  logic [DIV_WIDTH-1:0]    divider,
    input  logic                    wrDivider,
`ifdef SAMPLE_DECIMATOR_GROUP_MASK_EN
    input  logic [DATA_WIDTH/8-1:0] disabledGroups,
`endif
    output logic [DATA_WIDTH-1:0]   dataOutput,
    output logic                    validOut
);

    logic                  capture;
    logic [DATA_WIDTH-1:0] captured_word;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    decim_counter #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_decim_counter (
        .clock     (clock),
        .resetN    (resetN),
        .enable    (enable),
        .validIn   (validIn),
        .wrDivider (wrDivider),
        .divider   (divider),
        .capture   (capture)
    );

`ifdef SAMPLE_DECIMATOR_GROUP_MASK_EN
    assign captured_word = dataInput & ~group_mask(disabledGroups);
`else
    assign captured_word = dataInput;
`endif

    always_comb begin
        data_d  = data_q;
        valid_d = capture;
        if (capture) begin
            data_d = captured_word;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign dataOutput = data_q;
    assign validOut   = valid_q;

endmodule

// File: tb/tb_sample_decimator.sv
// Directed bench for sample_decimator with hand-computed expectations.
module tb_sample_decimator;

    logic        clock;
    logic        resetN;
    logic [31:0] dataInput;
    logic        validIn;
    logic        enable;
    logic [23:0] divider;
    logic        wrDivider;
`ifdef SAMPLE_DECIMATOR_GROUP_MASK_EN
    logic [3:0]  disabledGroups;
`endif
    logic [31:0] dataOutput;
    logic        validOut;

    int total = 0;
    int bad   = 0;

    sample_decimator dut (
        .clock          (clock),
        .resetN         (resetN),
        .dataInput      (dataInput),
        .validIn        (validIn),
        .enable         (enable),
        .divider        (divider),
        .wrDivider      (wrDivider),
`ifdef SAMPLE_DECIMATOR_GROUP_MASK_EN
        .disabledGroups (disabledGroups),
`endif
        .dataOutput     (dataOutput),
        .validOut       (validOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic v, input logic [31:0] d,
                       input logic ev, input logic [31:0] ed);
        validIn   = v;
        dataInput = d;
        @(posedge clock);
        #1;
        check({tag, ".valid"}, {31'd0, validOut}, {31'd0, ev});
        check({tag, ".data"}, dataOutput, ed);
    endtask

    task automatic wr(input string tag, input logic [23:0] div, input logic v,
                      input logic [31:0] d, input logic [31:0] ed);
        wrDivider = 1'b1;
        divider   = div;
        validIn   = v;
        dataInput = d;
        @(posedge clock);
        #1;
        check({tag, ".valid"}, {31'd0, validOut}, 32'd0);
        check({tag, ".data"}, dataOutput, ed);
        wrDivider = 1'b0;
    endtask

    initial begin
        resetN    = 1'b0;
        enable    = 1'b1;
        validIn   = 1'b0;
        dataInput = '0;
        divider   = '0;
        wrDivider = 1'b0;
`ifdef SAMPLE_DECIMATOR_GROUP_MASK_EN
        disabledGroups = 4'b0000;
`endif
        #2;
        check("reset.valid", {31'd0, validOut}, 32'd0);
        check("reset.data", dataOutput, 32'd0);
        #6 resetN = 1'b1;

        // divReg = 0 after reset: every valid word passes
        cyc("pass0", 1'b1, 32'h0, 1'b1, 32'h0);
        cyc("pass1", 1'b1, 32'h1, 1'b1, 32'h1);
        cyc("pass2", 1'b1, 32'h2, 1'b1, 32'h2);

        wr("wr_div3", 24'd3, 1'b0, 32'h0, 32'h2);
        for (int i = 0; i < 12; i++) begin
            cyc($sformatf("div4_%0d", i), 1'b1, 32'h10 + 32'(i),
                (i % 4) == 0, 32'h10 + 32'((i / 4) * 4));
        end

        wr("wr_div1", 24'd1, 1'b0, 32'h0, 32'h18);
        cyc("gapA",  1'b1, 32'h0A, 1'b1, 32'h0A);
        cyc("gap1",  1'b0, 32'h00, 1'b0, 32'h0A);
        cyc("gapB",  1'b1, 32'h0B, 1'b0, 32'h0A);
        cyc("gap2",  1'b0, 32'h00, 1'b0, 32'h0A);
        cyc("gapC",  1'b1, 32'h0C, 1'b1, 32'h0C);
        cyc("gap3",  1'b0, 32'h00, 1'b0, 32'h0C);
        cyc("gapD",  1'b1, 32'h0D, 1'b0, 32'h0C);

        wr("collide", 24'd2, 1'b1, 32'h55, 32'h0C);
        cyc("after_collide", 1'b1, 32'h56, 1'b1, 32'h56);
        cyc("collide_cnt",   1'b1, 32'h57, 1'b0, 32'h56);

        wr("wr_div5", 24'd5, 1'b0, 32'h0, 32'h56);
        cyc("d5_w0", 1'b1, 32'h60, 1'b1, 32'h60);
        cyc("d5_w1", 1'b1, 32'h61, 1'b0, 32'h60);
        cyc("d5_w2", 1'b1, 32'h62, 1'b0, 32'h60);
        enable = 1'b0;
        cyc("en_abort", 1'b1, 32'h63, 1'b0, 32'h60);
        enable = 1'b1;
        cyc("en_restart", 1'b1, 32'h64, 1'b1, 32'h64);

        // counter is 0 here, so this word would be captured if enable were high
        wr("wr_div5b", 24'd5, 1'b0, 32'h0, 32'h64);
        enable = 1'b0;
        cyc("en_suppress", 1'b1, 32'h70, 1'b0, 32'h64);
        enable = 1'b1;
        cyc("en_resume", 1'b1, 32'h71, 1'b1, 32'h71);

        #2 resetN = 1'b0;
        #1;
        check("midreset.valid", {31'd0, validOut}, 32'd0);
        check("midreset.data", dataOutput, 32'd0);
        #2 resetN = 1'b1;
        cyc("post_reset0", 1'b1, 32'h80, 1'b1, 32'h80);
        cyc("post_reset1", 1'b1, 32'h81, 1'b1, 32'h81);

`ifdef SAMPLE_DECIMATOR_GROUP_MASK_EN
        disabledGroups = 4'b0101;
        cyc("mask", 1'b1, 32'hAABBCCDD, 1'b1, 32'hAA00CC00);
        disabledGroups = 4'b0000;
        cyc("mask_idle", 1'b0, 32'h0, 1'b0, 32'hAA00CC00);
`else
        cyc("nomask", 1'b1, 32'hAABBCCDD, 1'b1, 32'hAABBCCDD);
        cyc("nomask_idle", 1'b0, 32'h0, 1'b0, 32'hAABBCCDD);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
